// File: rtl/prog_loader_if.sv
// Bundles the loader's nibble stream and the CPU fetch port.
// Stream handshake: a nibble moves on a rising edge where nib_valid && nib_ready; nib_data is ignored otherwise.
interface prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int NIB_W  = 4
);
  logic                nib_valid;
  logic [NIB_W-1:0]    nib_data;
  logic                nib_ready;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [2*NIB_W-1:0]  cpu_data;
  logic                cpu_hold;

  modport master (
    output nib_valid, nib_data, cpu_addr,
    input  nib_ready, cpu_data, cpu_hold
  );

  modport slave (
    input  nib_valid, nib_data, cpu_addr,
    output nib_ready, cpu_data, cpu_hold
  );
endinterface

// File: rtl/prog_loader.sv
// Program RAM with a nibble-stream loader; holds the CPU while a load runs.
// Tracks bytes written and an 8-bit additive checksum for the current/last load.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int NIB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic [7:0]        checksum,
  output logic [1:0]        dbg_state
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [2*NIB_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [NIB_W-1:0]     hi_reg;
  logic [2*NIB_W-1:0]   wr_byte;
  logic                 xfer;
  logic                 clr;
  logic                 take_hi;
  logic                 wr_en;

  assign xfer      = bus.nib_valid && bus.nib_ready;
  assign wr_byte   = {hi_reg, bus.nib_data};
  assign dbg_state = state;

  // start overrides everything, including a transfer on the same edge.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    take_hi   = 1'b0;
    wr_en     = 1'b0;
    if (start) begin
      state_nxt = WAIT_HI;
      clr       = 1'b1;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        WAIT_HI: begin
          if (xfer) begin
            take_hi   = 1'b1;
            state_nxt = WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (xfer) begin
            wr_en     = 1'b1;
            state_nxt = (wr_ptr == LAST) ? FINISH : WAIT_HI;
          end
        end
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.nib_ready <= 1'b0;
      bus.cpu_hold  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_count      <= '0;
      checksum      <= '0;
      wr_ptr        <= '0;
      hi_reg        <= '0;
    end else begin
      state         <= state_nxt;
      bus.nib_ready <= (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
      bus.cpu_hold  <= (state_nxt != IDLE);
      busy          <= (state_nxt != IDLE);
      done          <= (state_nxt == FINISH);
      if (clr) begin
        wr_ptr   <= '0;
        wr_count <= '0;
        checksum <= '0;
      end
      if (take_hi) hi_reg <= bus.nib_data;
      if (wr_en) begin
        checksum <= checksum + 8'(wr_byte);
        wr_count <= wr_count + (ADDR_W+1)'(1);
        wr_ptr   <= wr_ptr + ADDR_W'(1);
      end
    end
  end

  // RAM contents survive reset; only the write is suppressed during it.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= wr_byte;
  end

  assign bus.cpu_data = mem[bus.cpu_addr];
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset, full loads, gapped stream, restarts,
// start/transfer collision, read/write collision and mid-load reset.
module tb_prog_loader;
  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] wr_count;
  logic [7:0] checksum;
  logic [1:0] dbg_state;

  logic [7:0] exp_mem [16];
  int n_cmp;
  int n_err;

  prog_loader_if #(.ADDR_W(4), .NIB_W(4)) bus_if ();

  prog_loader #(.ADDR_W(4), .NIB_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus_if.slave),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .checksum  (checksum),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Holds nib_valid until the nibble is taken; leaves valid high for back-to-back use.
  task automatic send_nib(input logic [3:0] n);
    int k;
    bus_if.nib_valid = 1'b1;
    bus_if.nib_data  = n;
    k = 0;
    while (!bus_if.nib_ready && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) check("nib_accept", {31'd0, bus_if.nib_ready}, 32'd1);
    else tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic send_byte_gapped(input logic [7:0] b);
    for (int h = 0; h < 2; h++) begin
      bus_if.nib_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        bus_if.nib_data = 4'($urandom_range(0, 15));
        tick();
      end
      send_nib(h == 0 ? b[7:4] : b[3:0]);
    end
  endtask

  task automatic check_mem(input int a, input logic [7:0] exp);
    bus_if.cpu_addr = 4'(a);
    #1;
    check($sformatf("mem%0d", a), {24'd0, bus_if.cpu_data}, {24'd0, exp});
  endtask

  task automatic verify_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      bus_if.cpu_addr = 4'(a);
      #1;
      check($sformatf("%s_mem%0d", tag, a), {24'd0, bus_if.cpu_data}, {24'd0, exp_mem[a]});
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i << 4) | (15 - i));
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    bus_if.nib_valid = 1'b0;
    bus_if.nib_data  = 4'd0;
    bus_if.cpu_addr  = 4'd0;

    // 1: reset
    repeat (2) tick();
    check("rst_ready", {31'd0, bus_if.nib_ready}, 32'd0);
    check("rst_hold",  {31'd0, bus_if.cpu_hold},  32'd0);
    check("rst_busy",  {31'd0, busy},             32'd0);
    check("rst_done",  {31'd0, done},             32'd0);
    check("rst_count", {27'd0, wr_count},         32'd0);
    check("rst_csum",  {24'd0, checksum},         32'd0);
    check("rst_state", {30'd0, dbg_state},        32'd0);
    rst = 1'b0;
    tick();

    // 2: full back-to-back load
    pulse_start();
    check("t2_state", {30'd0, dbg_state}, 32'd1);
    check("t2_ready", {31'd0, bus_if.nib_ready}, 32'd1);
    check("t2_hold",  {31'd0, bus_if.cpu_hold},  32'd1);
    for (int i = 0; i < 16; i++) begin
      send_nib(pat(i)[7:4]);
      if (i == 15) check("t2_done_early", {31'd0, done}, 32'd0);
      send_nib(pat(i)[3:0]);
      exp_mem[i] = pat(i);
    end
    check("t2_done",      {31'd0, done},            32'd1);
    check("t2_hold_fin",  {31'd0, bus_if.cpu_hold}, 32'd1);
    bus_if.nib_valid = 1'b0;
    tick();
    check("t2_done_off",  {31'd0, done},            32'd0);
    check("t2_hold_off",  {31'd0, bus_if.cpu_hold}, 32'd0);
    check("t2_busy_off",  {31'd0, busy},            32'd0);
    check("t2_count",     {27'd0, wr_count},        32'd16);
    check("t2_csum",      {24'd0, checksum},        32'hF8);
    check_mem(5, 8'h5A);
    verify_mem("t2");

    // 3: nibbles offered in IDLE are ignored, then a gapped load
    bus_if.nib_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus_if.nib_data = 4'($urandom_range(0, 15));
      tick();
    end
    check("t3_idle_ready", {31'd0, bus_if.nib_ready}, 32'd0);
    check("t3_idle_count", {27'd0, wr_count},         32'd16);
    bus_if.nib_valid = 1'b0;
    verify_mem("t3_idle");
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte_gapped(pat(i));
    check("t3_done", {31'd0, done}, 32'd1);
    bus_if.nib_valid = 1'b0;
    tick();
    check("t3_count", {27'd0, wr_count}, 32'd16);
    check("t3_csum",  {24'd0, checksum}, 32'hF8);
    verify_mem("t3");

    // 4: restart after three bytes
    pulse_start();
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    bus_if.nib_valid = 1'b0;
    pulse_start();
    check("t4_restart_count", {27'd0, wr_count}, 32'd0);
    send_byte(8'h77);
    bus_if.nib_valid = 1'b0;
    exp_mem[0] = 8'h77; exp_mem[1] = 8'hB2; exp_mem[2] = 8'hC3;
    check_mem(0, 8'h77);
    check_mem(1, 8'hB2);
    check_mem(2, 8'hC3);
    check_mem(3, pat(3));
    check("t4_count", {27'd0, wr_count},        32'd1);
    check("t4_csum",  {24'd0, checksum},        32'h77);
    check("t4_hold",  {31'd0, bus_if.cpu_hold}, 32'd1);

    // 5: start on the same edge as the low nibble drops the pair
    pulse_start();
    send_nib(4'h5);
    bus_if.nib_valid = 1'b1;
    bus_if.nib_data  = 4'h6;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus_if.nib_valid = 1'b0;
    check("t5_state", {30'd0, dbg_state}, 32'd1);
    check("t5_count", {27'd0, wr_count},  32'd0);
    check_mem(0, 8'h77);
    check_mem(1, 8'hB2);
    send_byte(8'h3C);
    bus_if.nib_valid = 1'b0;
    exp_mem[0] = 8'h3C;
    check_mem(0, 8'h3C);
    check_mem(1, 8'hB2);
    check("t5_count2", {27'd0, wr_count}, 32'd1);
    check("t5_csum",   {24'd0, checksum}, 32'h3C);

    // 6: read/write collision on byte 0, then reset mid-load
    pulse_start();
    bus_if.cpu_addr = 4'd0;
    send_nib(4'h1);
    #1;
    check("t6_coll_old", {24'd0, bus_if.cpu_data}, 32'h3C);
    send_nib(4'h1);
    check("t6_coll_new", {24'd0, bus_if.cpu_data}, 32'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33; exp_mem[3] = 8'h44;
    check("t6_count_pre", {27'd0, wr_count}, 32'd4);
    send_nib(4'hE);
    bus_if.nib_valid = 1'b0;
    check("t6_state_lo", {30'd0, dbg_state}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_state", {30'd0, dbg_state},        32'd0);
    check("t6_hold",  {31'd0, bus_if.cpu_hold},  32'd0);
    check("t6_busy",  {31'd0, busy},             32'd0);
    check("t6_ready", {31'd0, bus_if.nib_ready}, 32'd0);
    check("t6_count", {27'd0, wr_count},         32'd0);
    check("t6_csum",  {24'd0, checksum},         32'd0);
    check_mem(4, 8'h4B);
    verify_mem("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
